// File: rtl/ext_unit_pipe.sv
// Registered immediate/jump-target extender with valid/ready handshake.
// A 2-entry skid buffer (main + skid) keeps In_ready registered while sustaining one request per cycle.
module ext_unit_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JIDX_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IMM_W-1:0]  Imm,
  input  logic [JIDX_W-1:0] Jidx,
  input  logic [DATA_W-1:0] Pc,
  input  logic [2:0]        Ext_op,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [DATA_W-1:0] Ext_result,
  output logic              Ext_illegal,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic              Illegal_sticky
);

  typedef enum logic [2:0] {
    OpZero   = 3'b000,
    OpSign   = 3'b001,
    OpUpper  = 3'b010,
    OpBranch = 3'b011,
    OpJump   = 3'b100
  } ext_op_e;

  // PC bits kept by a jump target: everything above the shifted index field.
  localparam logic [DATA_W-1:0] JMask = {DATA_W{1'b1}} << (JIDX_W + 2);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_ill_q, main_ill_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_ill_q, skid_ill_d;
  logic              ready_q, ready_d;
  logic              sticky_q, sticky_d;

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] new_res;
  logic              new_ill;
  logic              accept;
  logic              xfer;

  always_comb begin
    sext    = {{(DATA_W - IMM_W){Imm[IMM_W-1]}}, Imm};
    new_res = '0;
    new_ill = 1'b0;
    case (Ext_op)
      OpZero:   new_res = {{(DATA_W - IMM_W){1'b0}}, Imm};
      OpSign:   new_res = sext;
      OpUpper:  new_res = {Imm, {(DATA_W - IMM_W){1'b0}}};
      OpBranch: new_res = sext << 2;
      OpJump:   new_res = (Pc & JMask) | (DATA_W'(Jidx) << 2);
      default:  new_ill = 1'b1;
    endcase
  end

  // Reset gates In_ready directly so it is low during reset and high the first cycle after.
  assign In_ready       = ready_q & ~reset;
  assign Out_valid      = main_valid_q;
  assign Ext_result     = main_data_q;
  assign Ext_illegal    = main_ill_q;
  assign Illegal_sticky = sticky_q;

  assign accept = In_valid & In_ready;
  assign xfer   = main_valid_q & Out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ill_d   = skid_ill_q;
    sticky_d     = sticky_q | (accept & new_ill);

    if (skid_valid_q) begin
      // In_ready is low here, so only a drain into main can happen.
      if (xfer) begin
        main_data_d  = skid_data_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = new_res;
        main_ill_d   = new_ill;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = new_res;
        skid_ill_d   = new_ill;
      end
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end

    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ill_q   <= 1'b0;
      ready_q      <= 1'b1;
      sticky_q     <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ill_q   <= skid_ill_d;
      ready_q      <= ready_d;
      sticky_q     <= sticky_d;
    end
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, registered successor to the combinational immediate extender in the multicycle CPU datapath.
- Accepts an immediate, jump index, PC and extend mode through a valid/ready handshake.
- Produces the extended DATA_W operand one cycle later, through a 2-entry skid buffer so decode can stream one request per cycle.
- Adds two modes: branch offset (sign-extend then shift left 2) and J-type target formation.
- Flags illegal mode codes.

Parameters:
- DATA_W, 32, result and PC width; must be >= IMM_W+2 and >= JIDX_W+2.
- IMM_W, 16, immediate field width.
- JIDX_W, 26, jump index field width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Imm  input  IMM_W  immediate field.
- Jidx  input  JIDX_W  J-type index field.
- Pc  input  DATA_W  PC of the instruction (PC+4 value supplied by the datapath).
- Ext_op  input  3  extend mode.
- In_valid  input  1  request valid.
- In_ready  output  1  unit can accept a request this cycle.
- Ext_result  output  DATA_W  extended operand.
- Ext_illegal  output  1  current output entry came from an illegal Ext_op.
- Out_valid  output  1  Ext_result valid.
- Out_ready  input  1  consumer accepts the result.
- Illegal_sticky  output  1  an illegal op has been accepted since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; all state is cleared on the rising edge with reset=1.
- Reset values:
  - Out_valid=0, Ext_result=0, Ext_illegal=0, Illegal_sticky=0.
  - Both buffer entries invalid.
  - In_ready=0 while reset=1; In_ready=1 in the first cycle after reset deasserts.
- Modes (computed combinationally at accept, then registered):
  - 000 zero-extend: upper DATA_W-IMM_W bits are 0.
  - 001 sign-extend: replicate Imm[IMM_W-1].
  - 010 upper-load: Imm placed in bits DATA_W-1 down to DATA_W-IMM_W, lower bits 0.
  - 011 branch offset: sign-extend Imm to DATA_W, then shift left 2, dropping the top 2 bits.
  - 100 jump target: Pc[DATA_W-1:JIDX_W+2] concatenated with Jidx and 2'b00.
  - 101–111 illegal: result 0, Ext_illegal=1 for that entry, Illegal_sticky set.
- Handshake:
  - Accept when In_valid && In_ready.
  - Transfer out when Out_valid && Out_ready.
  - Upstream must hold its inputs stable while In_valid=1 and In_ready=0.
- Latency: 1 cycle. A request accepted at edge N is presented with Out_valid=1 after edge N, unless older entries are still queued ahead of it.
- Throughput: 1 request per cycle while Out_ready=1.
- Storage: 2 entries, main (drives the outputs) and skid. Results leave in strict FIFO order.
- In_ready is driven from a register and equals "skid entry empty". It has no combinational path from Out_ready.
- Buffer transitions:
  - Main empty, accept: load main.
  - Main full and transfer-out, accept: load main.
  - Main full, no transfer-out, accept: load skid; In_ready drops next cycle.
  - Skid full and transfer-out: skid moves to main; In_ready rises next cycle. In this state no accept is possible.
  - Transfer-out with no accept and skid empty: Out_valid=0 next cycle.
- Simultaneous accept and transfer-out in one cycle: both happen, and occupancy is unchanged.
- Out_valid=0: Ext_result and Ext_illegal hold their last values. The verifier checks them only while Out_valid=1.
- Illegal_sticky: set at accept of an illegal op (visible the cycle after accept). Cleared only by reset.
- Reset mid-operation: buffered entries are discarded and none are output afterwards.
- Widths: all arithmetic is truncated to DATA_W; no wrap detection.
- Size: a competent implementation is 120–400 lines of RTL.

Test Plan:
- Sign and zero extension, Out_ready=1:
  - Imm=16'h8001, op=001 -> Ext_result=32'hFFFF8001 one cycle later.
  - Same Imm, op=000 -> 32'h00008001.
- Upper-load and branch offset:
  - Imm=16'h1234, op=010 -> 32'h12340000.
  - Imm=16'hFFFF, op=011 -> 32'hFFFFFFFC.
  - Imm=16'h4000, op=011 -> 32'h00010000.
- Jump target: Pc=32'hA0000004, Jidx=26'h0000010, op=100 -> 32'hA0000040.
- Backpressure:
  - Out_ready=0, stream 3 requests: the first two are accepted, then In_ready=0.
  - Raise Out_ready: results emerge in order with no loss or duplication, and In_ready returns to 1 one cycle after the skid drains.
- Illegal op: op=110 -> Ext_result=0 and Ext_illegal=1 on that output; Illegal_sticky=1 afterwards, persisting through later legal ops until reset.
- Reset mid-stream:
  - Assert reset with 2 entries queued -> next cycle Out_valid=0 and Illegal_sticky=0.
  - After reset releases: In_ready=1 and no stale results appear.
